mac_kbd_queue: RTL and testbench

Keyboard-side protocol engine for the Mac Plus core. It consumes the toggle-strobed key events produced by the HID block (`kbd_strobe` / `kbd_data`) and expands each event into Mac Plus keyboard transmit bytes. It buffers those bytes in a FIFO and answers the byte-level commands the Mac sends over the VIA keyboard channel: Inquiry, Instant, Model and Test. It sits between the HID block and the VIA keyboard shifter.

---
 rtl/mac_kbd_queue.sv | 248 ++++++++++++++++++++++++
 tb/tb_mac_kbd_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_kbd_queue.sv
// Mac Plus keyboard protocol engine: expands HID key events into transmit bytes, queues them and
// answers Inquiry/Instant/Model/Test. Define MAC_KBD_EXT_EN to enable keypad prefix expansion.

module mac_kbd_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned INQ_TIMEOUT = 8000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_strobe,
  input  logic [9:0] kbd_data,
  input  logic       cmd_strobe,
  input  logic [7:0] cmd_data,
  output logic       resp_strobe,
  output logic [7:0] resp_data,
  output logic       overflow,
  output logic       fifo_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(INQ_TIMEOUT + 1);

  localparam logic [7:0] CMD_INQUIRY = 8'h10;
  localparam logic [7:0] CMD_INSTANT = 8'h14;
  localparam logic [7:0] CMD_MODEL   = 8'h16;
  localparam logic [7:0] CMD_TEST    = 8'h36;
  localparam logic [7:0] RESP_NULL   = 8'h7B;
  localparam logic [7:0] RESP_MODEL  = 8'h0B;
  localparam logic [7:0] RESP_TEST   = 8'h7D;

  typedef enum logic [1:0] {EXP_IDLE, EXP_CHK, EXP_PUSH} exp_state_e;
  typedef enum logic {CMD_READY, CMD_INQ_WAIT} cmd_state_e;

  exp_state_e    exp_q, exp_d;
  cmd_state_e    cmd_q, cmd_d;
  logic          strobe_q;
  logic          hold_full_q, hold_full_d;
  logic [9:0]    hold_q, hold_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q;
  logic          resp_strobe_q, resp_strobe_d;
  logic [7:0]    resp_data_q, resp_data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem [DEPTH];

  logic          evt, push, pop, flush, ovf_set, ovf_clr, ext_ok, nonempty;
  logic [AW:0]   seq_len, free_slots;
  logic [7:0]    seq_byte, key_byte, head;

  assign evt        = kbd_strobe ^ strobe_q;
  assign key_byte   = hold_q[7:0];
  assign free_slots = (AW+1)'(DEPTH) - level_q;
  assign nonempty   = (level_q != '0);
  assign head       = mem[rd_ptr_q];

`ifdef MAC_KBD_EXT_EN
  assign ext_ok = 1'b1;
  always_comb begin
    seq_len  = (AW+1)'(1);
    seq_byte = key_byte;
    if (hold_q[9]) begin
      seq_len = (AW+1)'(4);
      case (idx_q)
        2'd0:    seq_byte = 8'h71;
        2'd1:    seq_byte = 8'h79;
        2'd2:    seq_byte = key_byte;
        default: seq_byte = 8'hF1;
      endcase
    end else if (hold_q[8]) begin
      seq_len  = (AW+1)'(2);
      seq_byte = (idx_q == 2'd0) ? 8'h79 : key_byte;
    end
  end
`else
  // Keypad events are discarded without flagging overflow in this build.
  assign ext_ok   = ~(hold_q[9] | hold_q[8]);
  assign seq_len  = (AW+1)'(1);
  assign seq_byte = key_byte;
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    exp_d       = exp_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    push        = 1'b0;
    ovf_set     = 1'b0;
    case (exp_q)
      EXP_IDLE: if (hold_full_q) exp_d = EXP_CHK;
      EXP_CHK: begin
        if (!ext_ok) begin
          hold_full_d = 1'b0;
          exp_d       = EXP_IDLE;
        end else if (free_slots >= seq_len) begin
          idx_d = 2'd0;
          exp_d = EXP_PUSH;
        end else begin
          ovf_set     = 1'b1;
          hold_full_d = 1'b0;
          exp_d       = EXP_IDLE;
        end
      end
      EXP_PUSH: begin
        push = 1'b1;
        if ((AW+1)'(idx_q) == seq_len - (AW+1)'(1)) begin
          hold_full_d = 1'b0;
          exp_d       = EXP_IDLE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: exp_d = EXP_IDLE;
    endcase
    // A flush abandons whatever part of the event has not been written yet.
    if (flush && exp_q == EXP_PUSH) begin
      hold_full_d = 1'b0;
      exp_d       = EXP_IDLE;
    end
    if (evt) begin
      if (hold_full_q) begin
        ovf_set = 1'b1;
      end else begin
        hold_d      = kbd_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_comb begin
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    pop           = 1'b0;
    flush         = 1'b0;
    ovf_clr       = 1'b0;
    resp_strobe_d = 1'b0;
    resp_data_d   = resp_data_q;
    if (cmd_strobe) begin
      cmd_d = CMD_READY;
      case (cmd_data)
        CMD_INQUIRY: begin
          if (nonempty) begin
            pop           = 1'b1;
            resp_strobe_d = 1'b1;
            resp_data_d   = head;
          end else begin
            cmd_d = CMD_INQ_WAIT;
            cnt_d = CW'(INQ_TIMEOUT);
          end
        end
        CMD_INSTANT: begin
          pop           = nonempty;
          resp_strobe_d = 1'b1;
          resp_data_d   = nonempty ? head : RESP_NULL;
        end
        CMD_MODEL: begin
          resp_strobe_d = 1'b1;
          resp_data_d   = RESP_MODEL;
        end
        CMD_TEST: begin
          flush         = 1'b1;
          ovf_clr       = 1'b1;
          resp_strobe_d = 1'b1;
          resp_data_d   = RESP_TEST;
        end
        default: ;
      endcase
    end else if (cmd_q == CMD_INQ_WAIT) begin
      if (nonempty) begin
        pop           = 1'b1;
        resp_strobe_d = 1'b1;
        resp_data_d   = head;
        cmd_d         = CMD_READY;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          resp_strobe_d = 1'b1;
          resp_data_d   = RESP_NULL;
          cmd_d         = CMD_READY;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign overflow_d = (overflow_q & ~ovf_clr) | ovf_set;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q         <= EXP_IDLE;
      cmd_q         <= CMD_READY;
      strobe_q      <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      empty_q       <= 1'b1;
      resp_strobe_q <= 1'b0;
      resp_data_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      exp_q         <= exp_d;
      cmd_q         <= cmd_d;
      strobe_q      <= kbd_strobe;
      hold_full_q   <= hold_full_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      empty_q       <= (level_d == '0);
      resp_strobe_q <= resp_strobe_d;
      resp_data_q   <= resp_data_d;
      overflow_q    <= overflow_d;
    end
  end

  // NOTE: storage array has no reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= seq_byte;
  end

  assign resp_strobe = resp_strobe_q;
  assign resp_data   = resp_data_q;
  assign overflow    = overflow_q;
  assign fifo_empty  = empty_q;
endmodule

// File: tb/tb_mac_kbd_queue.sv
// Randomised bench for mac_kbd_queue against a queue-based model of the keyboard byte stream.
module tb_mac_kbd_queue;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned INQ_TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       kbd_strobe;
  logic [9:0] kbd_data;
  logic       cmd_strobe;
  logic [7:0] cmd_data;
  logic       resp_strobe;
  logic [7:0] resp_data;
  logic       overflow;
  logic       fifo_empty;

  always #5 clk = ~clk;

  mac_kbd_queue #(.DEPTH(DEPTH), .INQ_TIMEOUT(INQ_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .kbd_strobe(kbd_strobe), .kbd_data(kbd_data),
    .cmd_strobe(cmd_strobe), .cmd_data(cmd_data), .resp_strobe(resp_strobe),
    .resp_data(resp_data), .overflow(overflow), .fifo_empty(fifo_empty)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_q[$];
  logic       model_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bytes a key event contributes, queued atomically if they all fit.
  function automatic void model_event(input logic [9:0] d);
    logic [7:0] seq[$];
`ifdef MAC_KBD_EXT_EN
    if (d[9]) begin
      seq.push_back(8'h71); seq.push_back(8'h79); seq.push_back(d[7:0]); seq.push_back(8'hF1);
    end else if (d[8]) begin
      seq.push_back(8'h79); seq.push_back(d[7:0]);
    end else begin
      seq.push_back(d[7:0]);
    end
`else
    if (d[9] | d[8]) return;
    seq.push_back(d[7:0]);
`endif
    if (int'(DEPTH) - model_q.size() < seq.size()) model_ovf = 1'b1;
    else foreach (seq[i]) model_q.push_back(seq[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kbd_event(input logic [9:0] d);
    kbd_data   = d;
    kbd_strobe = ~kbd_strobe;
    repeat (9) tick();
    model_event(d);
  endtask

  task automatic cmd(input logic [7:0] c, input string tag, input logic exp_resp,
                     input logic [7:0] exp_data);
    cmd_data   = c;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    check({tag, "_strobe"}, 32'(resp_strobe), 32'(exp_resp));
    if (exp_resp) check({tag, "_data"}, 32'(resp_data), 32'(exp_data));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
  endtask

  task automatic instant(input string tag);
    logic [7:0] e;
    e = (model_q.size() != 0) ? model_q.pop_front() : 8'h7B;
    cmd(8'h14, tag, 1'b1, e);
  endtask

  task automatic test_cmd(input string tag);
    model_q.delete();
    model_ovf = 1'b0;
    cmd(8'h36, tag, 1'b1, 8'h7D);
    check({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
  endtask

  // Inquiry on an empty queue; optionally injects a plain event before edge inject_at.
  task automatic inquiry_wait(input string tag, input int inject_at, input logic [9:0] d,
                              input int exp_cycle, input logic [7:0] exp_data);
    int         first = 0;
    int         count = 0;
    logic [7:0] got = 8'h00;
    cmd_data   = 8'h10;
    cmd_strobe = 1'b1;
    tick();
    cmd_strobe = 1'b0;
    for (int n = 1; n <= 2 * int'(INQ_TIMEOUT); n++) begin
      if (n == inject_at) begin
        kbd_data   = d;
        kbd_strobe = ~kbd_strobe;
      end
      tick();
      if (resp_strobe) begin
        count++;
        if (first == 0) begin
          first = n;
          got   = resp_data;
        end
      end
    end
    check({tag, "_cycle"}, 32'(first), 32'(exp_cycle));
    check({tag, "_data"}, 32'(got), 32'(exp_data));
    check({tag, "_count"}, 32'(count), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, 32'(resp_strobe), 32'd0);
    check({tag, "_data"}, 32'(resp_data), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] d;
    int         r;
    reset      = 1'b1;
    kbd_strobe = 1'b0;
    kbd_data   = '0;
    cmd_strobe = 1'b0;
    cmd_data   = '0;
    model_ovf  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst_hold");
    reset = 1'b0;
    tick();
    check_reset_outputs("rst_rel");

    instant("inst_empty");
    cmd(8'h16, "model", 1'b1, 8'h0B);
    test_cmd("test0");

    kbd_event(10'h00A);
    instant("plain_0a");
    kbd_event(10'h08A);
    instant("break_8a");

    kbd_event(10'h20D);
    for (int i = 0; i < 5; i++) instant($sformatf("wrap_%0d", i));
    kbd_event(10'h15C);
    for (int i = 0; i < 3; i++) instant($sformatf("pfx_%0d", i));

    inquiry_wait("inq_to", 0, 10'h000, int'(INQ_TIMEOUT), 8'h7B);
    inquiry_wait("inq_ev", 40, 10'h033, 44, 8'h33);
    check("inq_ev_empty", 32'(fifo_empty), 32'd1);

    for (int i = 0; i <= int'(DEPTH); i++) kbd_event(10'(8'h20 + i));
    check("fill_ovf", 32'(overflow), 32'(model_ovf));
    check("fill_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
    for (int i = 0; i < int'(DEPTH); i++) instant($sformatf("fill_rd_%0d", i));
    kbd_event(10'h044);
    test_cmd("test_fill");

    kbd_data   = 10'h041;
    kbd_strobe = ~kbd_strobe;
    tick();
    kbd_data   = 10'h042;
    kbd_strobe = ~kbd_strobe;
    repeat (9) tick();
    model_event(10'h041);
    model_ovf = 1'b1;
    check("dbl_ovf", 32'(overflow), 32'(model_ovf));
    instant("dbl_rd0");
    instant("dbl_rd1");
    test_cmd("test_dbl");

    kbd_event(10'h011);
    kbd_data   = 10'h20D;
    kbd_strobe = ~kbd_strobe;
    repeat (5) tick();
    reset      = 1'b1;
    kbd_strobe = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    reset = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    repeat (8) tick();
    check("rst_after_empty", 32'(fifo_empty), 32'd1);
    instant("rst_after_inst");

    repeat (80) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        d = 10'($urandom);
        if ($urandom_range(0, 3) != 0) d[9:8] = 2'b00;
        kbd_event(d);
        check("rnd_ev_ovf", 32'(overflow), 32'(model_ovf));
        check("rnd_ev_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
      end else if (r <= 6) begin
        instant("rnd_inst");
      end else if (r == 7 && model_q.size() != 0) begin
        cmd(8'h10, "rnd_inq", 1'b1, model_q.pop_front());
      end else if (r == 8) begin
        cmd(8'h16, "rnd_model", 1'b1, 8'h0B);
      end else begin
        cmd(8'h55, "rnd_unk", 1'b0, 8'h00);
      end
    end
    check("final_ovf", 32'(overflow), 32'(model_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
